// File: rtl/ma_xif_dispatcher.sv
// ma_xif_dispatcher
//   CV-X-IF fan-out from one core to NUM_ACC matrix accelerators.
//   Issue  : matching-opcode instructions are steered round-robin to the first
//            accelerator with spare credit. The accepting accelerator is recorded
//            as the owner of the instruction ID.
//   Commit : each commit is routed to the owner of its ID. A kill releases the
//            ownership record and the owner's credit.
//   Result : accelerator results are arbitrated round-robin into one registered
//            result stage toward the core. A result whose ID is not owned by the
//            returning accelerator is still forwarded, and it sets a sticky error.
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   s_issue_* / m_issue_*    core-side issue request / per-accelerator issue fan-out
//   s_commit_* / m_commit_*  core-side commit / one-hot commit to the owner
//   m_result_*               packed per-accelerator results (slot k at [k*W +: W])
//   s_result_*               registered result toward the core
//   err_ownership            sticky ownership-violation flag
module ma_xif_dispatcher #(
   parameter int unsigned NUM_ACC         = 4,
   parameter int unsigned ID_WIDTH        = 4,
   parameter int unsigned XLEN            = 64,
   parameter logic [6:0]  OPCODE          = 7'h2B,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_issue_valid,
   output logic                         s_issue_ready,
   input  logic [31:0]                  s_issue_instr,
   input  logic [ID_WIDTH-1:0]          s_issue_id,
   output logic                         s_issue_accept,
   output logic                         s_issue_writeback,
   output logic [NUM_ACC-1:0]           m_issue_valid,
   input  logic [NUM_ACC-1:0]           m_issue_ready,
   input  logic [NUM_ACC-1:0]           m_issue_accept,
   input  logic [NUM_ACC-1:0]           m_issue_writeback,
   output logic [31:0]                  m_issue_instr,
   output logic [ID_WIDTH-1:0]          m_issue_id,
   input  logic                         s_commit_valid,
   input  logic [ID_WIDTH-1:0]          s_commit_id,
   input  logic                         s_commit_kill,
   output logic [NUM_ACC-1:0]           m_commit_valid,
   output logic [ID_WIDTH-1:0]          m_commit_id,
   output logic                         m_commit_kill,
   input  logic [NUM_ACC-1:0]           m_result_valid,
   output logic [NUM_ACC-1:0]           m_result_ready,
   input  logic [NUM_ACC*ID_WIDTH-1:0]  m_result_id,
   input  logic [NUM_ACC*XLEN-1:0]      m_result_data,
   input  logic [NUM_ACC*5-1:0]         m_result_rd,
   input  logic [NUM_ACC-1:0]           m_result_we,
   output logic                         s_result_valid,
   input  logic                         s_result_ready,
   output logic [ID_WIDTH-1:0]          s_result_id,
   output logic [XLEN-1:0]              s_result_data,
   output logic [4:0]                   s_result_rd,
   output logic                         s_result_we,
   output logic                         err_ownership
);
   localparam int unsigned AW  = $clog2(NUM_ACC);
   localparam int unsigned AW1 = AW + 1;
   localparam int unsigned CW  = $clog2(MAX_OUTSTANDING + 1);
   localparam int unsigned NID = 2 ** ID_WIDTH;
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
   localparam logic [AW:0]   NACC    = AW1'(NUM_ACC);

   // Ownership table: owner_q is only meaningful where owner_vld_q is set.
   logic [AW-1:0]       owner_q [NID];
   logic [AW-1:0]       owner_d [NID];
   logic [NID-1:0]      owner_vld_q, owner_vld_d;
   logic [CW-1:0]       cnt_q [NUM_ACC];
   logic [CW-1:0]       cnt_d [NUM_ACC];
   logic [AW-1:0]       issue_rr_q, issue_rr_d, res_rr_q, res_rr_d;
   logic                res_valid_q, res_valid_d, res_we_q, res_we_d, err_q, err_d;
   logic [ID_WIDTH-1:0] res_id_q, res_id_d;
   logic [XLEN-1:0]     res_data_q, res_data_d;
   logic [4:0]          res_rd_q, res_rd_d;

   // Unpacked views of the result buses
   logic [ID_WIDTH-1:0] rid_w   [NUM_ACC];
   logic [XLEN-1:0]     rdata_w [NUM_ACC];
   logic [4:0]          rrd_w   [NUM_ACC];

   // (base + off) mod NUM_ACC, valid for off < NUM_ACC and any NUM_ACC
   function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input int unsigned off);
      logic [AW:0] s;
      s = {1'b0, base} + AW1'(off);
      if (s >= NACC) s = s - NACC;
      return s[AW-1:0];
   endfunction

   // ---------------- Issue path ----------------
   logic          is_match, have_credit, issue_stall, issue_fire;
   logic [AW-1:0] tgt;

   assign is_match = (s_issue_instr[6:0] == OPCODE);

   always_comb begin
      logic [AW-1:0] cand;
      tgt         = issue_rr_q;
      have_credit = 1'b0;
      for (int unsigned j = 0; j < NUM_ACC; j++) begin
         cand = wrap_add(issue_rr_q, j);
         if (!have_credit && (cnt_q[cand] < CNT_MAX)) begin
            tgt         = cand;
            have_credit = 1'b1;
         end
      end
   end

   // ID reuse is blocked on the registered table, so a same-cycle release only
   // becomes visible to issue one cycle later.
   assign issue_stall = !have_credit || owner_vld_q[s_issue_id];
   assign issue_fire  = s_issue_valid && is_match && !issue_stall &&
                        m_issue_ready[tgt] && m_issue_accept[tgt];

   always_comb begin
      m_issue_valid     = '0;
      s_issue_ready     = 1'b0;
      s_issue_accept    = 1'b0;
      s_issue_writeback = 1'b0;
      if (!is_match) begin
         s_issue_ready = s_issue_valid;
      end else if (!issue_stall) begin
         m_issue_valid[tgt] = s_issue_valid;
         s_issue_ready      = s_issue_valid & m_issue_ready[tgt];
         s_issue_accept     = s_issue_valid & m_issue_accept[tgt];
         s_issue_writeback  = s_issue_valid & m_issue_writeback[tgt];
      end
   end

   assign m_issue_instr = s_issue_instr;
   assign m_issue_id    = s_issue_id;

   // ---------------- Commit path ----------------
   logic          cmt_hit, kill_fire;
   logic [AW-1:0] cmt_own;

   assign cmt_hit   = s_commit_valid && owner_vld_q[s_commit_id];
   assign cmt_own   = owner_q[s_commit_id];
   assign kill_fire = cmt_hit && s_commit_kill;

   always_comb begin
      m_commit_valid = '0;
      if (cmt_hit) m_commit_valid[cmt_own] = 1'b1;
   end

   assign m_commit_id   = s_commit_id;
   assign m_commit_kill = s_commit_kill;

   // ---------------- Result path ----------------
   logic                res_load, gnt_vld, res_fire, own_ok;
   logic [AW-1:0]       gnt;
   logic [ID_WIDTH-1:0] gnt_id;

   assign res_load = !res_valid_q || s_result_ready;

   always_comb begin
      logic [AW-1:0] cand;
      gnt     = res_rr_q;
      gnt_vld = 1'b0;
      for (int unsigned j = 0; j < NUM_ACC; j++) begin
         cand = wrap_add(res_rr_q, j);
         if (!gnt_vld && m_result_valid[cand]) begin
            gnt     = cand;
            gnt_vld = 1'b1;
         end
      end
   end

   assign res_fire = res_load && gnt_vld;
   assign gnt_id   = rid_w[gnt];
   assign own_ok   = owner_vld_q[gnt_id] && (owner_q[gnt_id] == gnt);

   always_comb begin
      m_result_ready = '0;
      if (res_fire) m_result_ready[gnt] = 1'b1;
   end

   // ---------------- Next state ----------------
   always_comb begin
      owner_d     = owner_q;
      owner_vld_d = owner_vld_q;
      issue_rr_d  = issue_rr_q;
      res_rr_d    = res_rr_q;
      res_valid_d = res_valid_q;
      res_id_d    = res_id_q;
      res_data_d  = res_data_q;
      res_rd_d    = res_rd_q;
      res_we_d    = res_we_q;
      err_d       = err_q;
      if (kill_fire) owner_vld_d[s_commit_id] = 1'b0;
      if (res_fire && own_ok) owner_vld_d[gnt_id] = 1'b0;
      // Set after clears so an issue wins over a release of the same ID
      if (issue_fire) begin
         owner_vld_d[s_issue_id] = 1'b1;
         owner_d[s_issue_id]     = tgt;
         issue_rr_d              = wrap_add(tgt, 1);
      end
      if (res_load) begin
         res_valid_d = gnt_vld;
         if (gnt_vld) begin
            res_id_d   = gnt_id;
            res_data_d = rdata_w[gnt];
            res_rd_d   = rrd_w[gnt];
            res_we_d   = m_result_we[gnt];
         end
      end
      if (res_fire) begin
         res_rr_d = wrap_add(gnt, 1);
         if (!own_ok) err_d = 1'b1;
      end
   end

   // Per-accelerator unpacking and credit accounting (issue, kill and result
   // may all hit the same accelerator in one cycle)
   for (genvar gi = 0; gi < NUM_ACC; gi++) begin : g_acc
      logic          inc, dec_kill, dec_res;
      logic [CW+1:0] sum_w;

      assign rid_w[gi]   = m_result_id[gi*ID_WIDTH +: ID_WIDTH];
      assign rdata_w[gi] = m_result_data[gi*XLEN +: XLEN];
      assign rrd_w[gi]   = m_result_rd[gi*5 +: 5];

      assign inc      = issue_fire && (tgt == AW'(gi));
      assign dec_kill = kill_fire && (cmt_own == AW'(gi));
      assign dec_res  = res_fire && own_ok && (gnt == AW'(gi));
      assign sum_w    = {2'b00, cnt_q[gi]} + {{(CW+1){1'b0}}, inc}
                      - {{(CW+1){1'b0}}, dec_kill} - {{(CW+1){1'b0}}, dec_res};
      assign cnt_d[gi] = sum_w[CW-1:0];

      // An underflow shows up as a huge sum_w, an overflow as a value past the limit
      a_cnt_no_wrap: assert property (@(posedge clk) disable iff (rst)
                                      sum_w <= {2'b00, CNT_MAX});
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_vld_q <= '0;
         issue_rr_q  <= '0;
         res_rr_q    <= '0;
         res_valid_q <= 1'b0;
         res_id_q    <= '0;
         res_data_q  <= '0;
         res_rd_q    <= '0;
         res_we_q    <= 1'b0;
         err_q       <= 1'b0;
         for (int unsigned k = 0; k < NUM_ACC; k++) cnt_q[k] <= '0;
      end else begin
         owner_vld_q <= owner_vld_d;
         issue_rr_q  <= issue_rr_d;
         res_rr_q    <= res_rr_d;
         res_valid_q <= res_valid_d;
         res_id_q    <= res_id_d;
         res_data_q  <= res_data_d;
         res_rd_q    <= res_rd_d;
         res_we_q    <= res_we_d;
         err_q       <= err_d;
         for (int unsigned k = 0; k < NUM_ACC; k++) cnt_q[k] <= cnt_d[k];
      end
   end

   // Owner entries need no reset: they are ignored while their valid bit is low
   always_ff @(posedge clk) begin
      owner_q <= owner_d;
   end

   assign s_result_valid = res_valid_q;
   assign s_result_id    = res_id_q;
   assign s_result_data  = res_data_q;
   assign s_result_rd    = res_rd_q;
   assign s_result_we    = res_we_q;
   assign err_ownership  = err_q;

endmodule
